conv_settle_sequencer: RTL

Sequencer that owns one `op_amp_with_frac` converter instance and runs one conversion per accepted request. For each request it applies the input code and pulses the converter reset. It then watches the converter's sample strobe until the output holds the same value for a programmed number of consecutive samples, and returns that value with a stable/timeout flag. It sits between a code source (sweep engine or host register) and the converter. It replaces testbench-only stability checking with synthesizable sequencing.

---
 rtl/conv_settle_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/conv_settle_sequencer.sv
// conv_settle_sequencer: runs one converter conversion per request,
// pulsing converter reset and waiting for a settled output value.
module conv_settle_sequencer #(
   parameter int IN_W        = 16,
   parameter int OUT_W       = 32,
   parameter int RST_CYCLES  = 10,
   parameter int STABLE_CNT  = 20,
   parameter int TIMEOUT_SMP = 1000,
   parameter int CNT_W       = 10
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req_valid,
   input  logic [IN_W-1:0]  req_code,
   output logic             req_ready,
   output logic             conv_reset_n,
   output logic [IN_W-1:0]  conv_in,
   input  logic [OUT_W-1:0] conv_out,
   input  logic             conv_strobe,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [OUT_W-1:0] rsp_data,
   output logic             rsp_stable,
   output logic [CNT_W-1:0] rsp_samples,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE,
      RESET,
      SETTLE,
      RESP
   } state_t;

   localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RW-1:0]    RST_LAST = RW'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STB_LIM  = CNT_W'(STABLE_CNT);
   localparam logic [CNT_W-1:0] TMO_LIM  = CNT_W'(TIMEOUT_SMP);

   state_t           state;
   state_t           state_n;
   logic [RW-1:0]    rst_cnt;
   logic [RW-1:0]    rst_cnt_n;
   logic [CNT_W-1:0] smp_cnt;
   logic [CNT_W-1:0] smp_cnt_n;
   logic [CNT_W-1:0] mat_cnt;
   logic [CNT_W-1:0] mat_cnt_n;
   logic [OUT_W-1:0] prev;
   logic [OUT_W-1:0] prev_n;
   logic [IN_W-1:0]  code_q;
   logic [IN_W-1:0]  code_n;
   logic             stable_q;
   logic             stable_n;
   logic             strobe_d;
   logic             rst_lo;
   logic             smp_ev;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   assign smp_ev = conv_strobe & ~strobe_d;

   // Next-state, counter and sample bookkeeping for one conversion.
   always_comb begin
      state_n   = state;
      rst_cnt_n = rst_cnt;
      smp_cnt_n = smp_cnt;
      mat_cnt_n = mat_cnt;
      prev_n    = prev;
      code_n    = code_q;
      stable_n  = stable_q;
      unique case (state)
         IDLE: begin
            if (req_valid) begin
               code_n    = req_code;
               rst_cnt_n = '0;
               smp_cnt_n = '0;
               mat_cnt_n = '0;
               stable_n  = 1'b0;
               state_n   = RESET;
            end
         end
         RESET: begin
            if (rst_cnt == RST_LAST) begin
               state_n = SETTLE;
            end else begin
               rst_cnt_n = rst_cnt + 1'b1;
            end
         end
         SETTLE: begin
            if (smp_ev) begin
               smp_cnt_n = sat_inc(smp_cnt);
               if (smp_cnt == '0) begin
                  mat_cnt_n = '0;
               end else if (conv_out == prev) begin
                  mat_cnt_n = sat_inc(mat_cnt);
               end else begin
                  mat_cnt_n = '0;
               end
               prev_n = conv_out;
               if (mat_cnt_n == STB_LIM) begin
                  stable_n = 1'b1;
                  state_n  = RESP;
               end else if (smp_cnt_n == TMO_LIM) begin
                  stable_n = 1'b0;
                  state_n  = RESP;
               end
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State and datapath registers; async reset discards any conversion.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         rst_cnt  <= '0;
         smp_cnt  <= '0;
         mat_cnt  <= '0;
         prev     <= '0;
         code_q   <= '0;
         stable_q <= 1'b0;
         strobe_d <= 1'b0;
         rst_lo   <= 1'b0;
      end else begin
         state    <= state_n;
         rst_cnt  <= rst_cnt_n;
         smp_cnt  <= smp_cnt_n;
         mat_cnt  <= mat_cnt_n;
         prev     <= prev_n;
         code_q   <= code_n;
         stable_q <= stable_n;
         strobe_d <= conv_strobe;
         rst_lo   <= (state_n == RESET);
      end
   end

   // Converter reset comes from a flop; external reset also holds it low.
   assign conv_reset_n = reset_n & ~rst_lo;
   assign conv_in      = code_q;
   assign req_ready    = reset_n & (state == IDLE);
   assign busy         = (state != IDLE);
   assign rsp_valid    = (state == RESP);
   assign rsp_data     = prev;
   assign rsp_stable   = stable_q;
   assign rsp_samples  = smp_cnt;

endmodule
